// File: rtl/m_stage_pkg.sv
// Shared encodings and sizing for the memory stage.
package m_stage_pkg;

    localparam int unsigned DmWords = 4096;
    localparam int unsigned DmAw    = 12;

    typedef enum logic [1:0] {
        WD_MRD = 2'b00,
        WD_AO  = 2'b01,
        WD_PC8 = 2'b10
    } wd_sel_e;

    typedef enum logic [2:0] {
        MT_W  = 3'b000,
        MT_HS = 3'b001,
        MT_HU = 3'b010,
        MT_BS = 3'b011,
        MT_BU = 3'b100
    } mem_type_e;

endpackage

// File: rtl/m_stage_if.sv
// E->M handshake and M-stage result bundle.
interface m_stage_if;

    logic        flush_i;
    logic [31:0] pc_i;
    logic [1:0]  Tnew_i;
    logic [31:0] ao_i;
    logic [31:0] wdata_i;
    logic [31:0] pcadd4_i;
    logic        RegWE_i;
    logic [1:0]  wd_sel_i;
    logic [4:0]  a3_i;
    logic        mem_we_i;
    logic [2:0]  mem_type_i;

    logic [31:0] pc_o;
    logic [1:0]  Tnew_o;
    logic        RegWE_o;
    logic [1:0]  wd_sel_o;
    logic [4:0]  a3_o;
    logic [31:0] ao_o;
    logic [31:0] pcadd4_o;
    logic [31:0] mrd_o;
    logic [31:0] fwd_data_o;
    logic        addr_err_o;

    modport master (
        output flush_i, pc_i, Tnew_i, ao_i, wdata_i, pcadd4_i, RegWE_i, wd_sel_i, a3_i,
               mem_we_i, mem_type_i,
        input  pc_o, Tnew_o, RegWE_o, wd_sel_o, a3_o, ao_o, pcadd4_o, mrd_o, fwd_data_o,
               addr_err_o
    );

    modport slave (
        input  flush_i, pc_i, Tnew_i, ao_i, wdata_i, pcadd4_i, RegWE_i, wd_sel_i, a3_i,
               mem_we_i, mem_type_i,
        output pc_o, Tnew_o, RegWE_o, wd_sel_o, a3_o, ao_o, pcadd4_o, mrd_o, fwd_data_o,
               addr_err_o
    );

endinterface

// File: rtl/m_stage_dm_ram.sv
// Data memory: word array with synchronous clear, byte-enable write, asynchronous read.
module m_stage_dm_ram #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/m_stage.sv
// Memory stage: E->M pipeline register, data memory access, load extension and address check.
module m_stage
    import m_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = DmWords,
    parameter int unsigned DM_AW    = DmAw
) (
    input logic   clk,
    input logic   reset,
    m_stage_if.slave bus
);

    logic [31:0] pc_q, ao_q, wdata_q, pcadd4_q;
    logic [1:0]  tnew_q, wd_sel_q;
    logic        regwe_q, mem_we_q;
    logic [4:0]  a3_q;
    logic [2:0]  mem_type_q;

    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            pc_q       <= '0;
            tnew_q     <= '0;
            regwe_q    <= 1'b0;
            wd_sel_q   <= '0;
            a3_q       <= '0;
            ao_q       <= '0;
            wdata_q    <= '0;
            pcadd4_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_type_q <= '0;
        end else begin
            pc_q       <= bus.pc_i;
            tnew_q     <= (bus.Tnew_i == 2'd0) ? 2'd0 : bus.Tnew_i - 2'd1;
            regwe_q    <= bus.RegWE_i;
            wd_sel_q   <= bus.wd_sel_i;
            a3_q       <= bus.a3_i;
            ao_q       <= bus.ao_i;
            wdata_q    <= bus.wdata_i;
            pcadd4_q   <= bus.pcadd4_i;
            mem_we_q   <= bus.mem_we_i;
            mem_type_q <= bus.mem_type_i;
        end
    end

    logic        is_load, misalign, out_of_range, addr_err, store_we;
    logic [3:0]  be;
    logic [31:0] wlanes, rdata, merged, ext;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        misalign = 1'b0;
        be       = 4'b0000;
        wlanes   = '0;
        case (mem_type_q)
            MT_W: begin
                misalign = (ao_q[1:0] != 2'b00);
                be       = 4'b1111;
                wlanes   = wdata_q;
            end
            MT_HS, MT_HU: begin
                misalign = ao_q[0];
                be       = ao_q[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata_q[15:0]}};
            end
            MT_BS, MT_BU: begin
                be     = 4'b0001 << ao_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            default: ;
        endcase
    end

    assign is_load      = (wd_sel_q == WD_MRD) && regwe_q;
    assign out_of_range = (ao_q >= DM_WORDS * 4);
    assign addr_err     = (is_load || mem_we_q) && (misalign || out_of_range);
    // Reset wins over a store sitting in M; the array is being cleared anyway.
    assign store_we     = mem_we_q && !addr_err && !reset;

    m_stage_dm_ram #(
        .WORDS (DM_WORDS),
        .AW    (DM_AW)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .we    (store_we),
        .be    (be),
        .addr  (ao_q[DM_AW+1:2]),
        .wdata (wlanes),
        .rdata (rdata)
    );

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wlanes[8*b +: 8] : rdata[8*b +: 8];
        end
    end

    always_comb begin
        half_lane = ao_q[1] ? rdata[31:16] : rdata[15:0];
        case (ao_q[1:0])
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        case (mem_type_q)
            MT_W:    ext = rdata;
            MT_HS:   ext = {{16{half_lane[15]}}, half_lane};
            MT_HU:   ext = {16'h0000, half_lane};
            MT_BS:   ext = {{24{byte_lane[7]}}, byte_lane};
            MT_BU:   ext = {24'h000000, byte_lane};
            default: ext = '0;
        endcase
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (store_we) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {ao_q[31:2], 2'b00}, merged);
        end
    end
`endif

    assign bus.pc_o       = pc_q;
    assign bus.Tnew_o     = tnew_q;
    assign bus.RegWE_o    = regwe_q;
    assign bus.wd_sel_o   = wd_sel_q;
    assign bus.a3_o       = a3_q;
    assign bus.ao_o       = ao_q;
    assign bus.pcadd4_o   = pcadd4_q;
    assign bus.mrd_o      = addr_err ? 32'h0 : ext;
    assign bus.fwd_data_o = (wd_sel_q == WD_PC8) ? pcadd4_q : ao_q;
    assign bus.addr_err_o = addr_err;

endmodule

// File: tb/tb_m_stage.sv
// Randomised bench for m_stage against a byte-addressed reference model.
module tb_m_stage;
    import m_stage_pkg::*;

    localparam int unsigned DmBytes = DmWords * 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ao;
        logic [31:0] wdata;
        logic [31:0] pcadd4;
        logic [1:0]  tnew;
        logic [1:0]  wd_sel;
        logic        regwe;
        logic        mem_we;
        logic [2:0]  mtype;
        logic [4:0]  a3;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    m_stage_if bus ();

    m_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          num_checks = 0;
    int          num_errors = 0;
    logic [7:0]  ref_mem [DmBytes];
    stim_t       mreg = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_load(input stim_t m);
        return m.regwe && (m.wd_sel == 2'b00);
    endfunction

    function automatic bit ref_err(input stim_t m);
        bit bad;
        bad = (m.ao >= DmBytes);
        if (m.mtype == 3'd0 && (m.ao % 4) != 0) bad = 1'b1;
        if ((m.mtype == 3'd1 || m.mtype == 3'd2) && (m.ao % 2) != 0) bad = 1'b1;
        return (ref_is_load(m) || m.mem_we) && bad;
    endfunction

    function automatic logic [31:0] ref_load(input stim_t m);
        int unsigned base;
        int unsigned hoff;
        logic [15:0] h;
        logic [7:0]  b;
        if (ref_err(m)) return 32'h0;
        base = (m.ao % DmBytes) & ~32'd3;
        hoff = base + (m.ao & 32'd2);
        h = {ref_mem[hoff + 1], ref_mem[hoff]};
        b = ref_mem[base + (m.ao & 32'd3)];
        case (m.mtype)
            3'd0:    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            default: return {24'h0, b};
        endcase
    endfunction

    task automatic ref_commit(input stim_t m);
        int unsigned n;
        if (!m.mem_we || ref_err(m)) return;
        n = (m.mtype == 3'd0) ? 4 : (m.mtype <= 3'd2) ? 2 : 1;
        for (int i = 0; i < int'(n); i++) begin
            ref_mem[m.ao + i] = m.wdata[8*i +: 8];
        end
    endtask

    task automatic compare_all();
        check("pc", bus.pc_o, mreg.pc);
        check("tnew", 32'(bus.Tnew_o), 32'(mreg.tnew));
        check("regwe", 32'(bus.RegWE_o), 32'(mreg.regwe));
        check("wd_sel", 32'(bus.wd_sel_o), 32'(mreg.wd_sel));
        check("a3", 32'(bus.a3_o), 32'(mreg.a3));
        check("ao", bus.ao_o, mreg.ao);
        check("pcadd4", bus.pcadd4_o, mreg.pcadd4);
        check("fwd", bus.fwd_data_o, (mreg.wd_sel == 2'b10) ? mreg.pcadd4 : mreg.ao);
        check("addr_err", 32'(bus.addr_err_o), 32'(ref_err(mreg)));
        if (ref_is_load(mreg)) check("mrd", bus.mrd_o, ref_load(mreg));
    endtask

    task automatic step(input stim_t s, input logic rst, input logic flush);
        @(negedge clk);
        reset          = rst;
        bus.flush_i    = flush;
        bus.pc_i       = s.pc;
        bus.Tnew_i     = s.tnew;
        bus.ao_i       = s.ao;
        bus.wdata_i    = s.wdata;
        bus.pcadd4_i   = s.pcadd4;
        bus.RegWE_i    = s.regwe;
        bus.wd_sel_i   = s.wd_sel;
        bus.a3_i       = s.a3;
        bus.mem_we_i   = s.mem_we;
        bus.mem_type_i = s.mtype;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(DmBytes); i++) ref_mem[i] = 8'h00;
            mreg = '0;
        end else begin
            ref_commit(mreg);
            if (flush) begin
                mreg = '0;
            end else begin
                mreg = s;
                mreg.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
            end
        end
        #1;
        compare_all();
    endtask

    function automatic stim_t mk_load(input logic [31:0] a, input logic [2:0] t);
        stim_t s = '0;
        s.pc = 32'h3000 + a; s.ao = a; s.mtype = t; s.regwe = 1'b1;
        s.wd_sel = 2'b00; s.a3 = 5'd9; s.tnew = 2'd2; s.pcadd4 = 32'h3008 + a;
        return s;
    endfunction

    function automatic stim_t mk_store(input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] t);
        stim_t s = '0;
        s.pc = 32'h3400 + a; s.ao = a; s.wdata = d; s.mtype = t; s.mem_we = 1'b1;
        s.wd_sel = 2'b01;
        return s;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, 63));
        if (r < 9) return 32'h3ff0 + 32'($urandom_range(0, 31));
        return $urandom;
    endfunction

    initial begin
        stim_t s;
        stim_t nop = '0;
        for (int i = 0; i < int'(DmBytes); i++) ref_mem[i] = 8'h00;
        bus.flush_i = 1'b0; bus.pc_i = '0; bus.Tnew_i = '0; bus.ao_i = '0; bus.wdata_i = '0;
        bus.pcadd4_i = '0; bus.RegWE_i = 1'b0; bus.wd_sel_i = '0; bus.a3_i = '0;
        bus.mem_we_i = 1'b0; bus.mem_type_i = '0;

        step(nop, 1'b1, 1'b0);
        step(nop, 1'b1, 1'b0);
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_fwd", bus.fwd_data_o, 32'h0);
        step(mk_load(32'h0, 3'd0), 1'b0, 1'b0);
        check("rd0", bus.mrd_o, 32'h0);

        step(mk_store(32'h10, 32'h8badf00d, 3'd0), 1'b0, 1'b0);
        step(mk_load(32'h10, 3'd0), 1'b0, 1'b0);
        check("sw_lw", bus.mrd_o, 32'h8badf00d);

        step(mk_store(32'h11, 32'h000000aa, 3'd3), 1'b0, 1'b0);
        step(mk_load(32'h11, 3'd3), 1'b0, 1'b0);
        check("lb", bus.mrd_o, 32'hffffffaa);
        step(mk_load(32'h11, 3'd4), 1'b0, 1'b0);
        check("lbu", bus.mrd_o, 32'h000000aa);
        step(mk_load(32'h10, 3'd0), 1'b0, 1'b0);
        check("lw_sb", bus.mrd_o, 32'h8badaa0d);

        step(mk_store(32'h12, 32'h00001234, 3'd2), 1'b0, 1'b0);
        step(mk_load(32'h12, 3'd1), 1'b0, 1'b0);
        check("lh", bus.mrd_o, 32'h00001234);
        step(mk_load(32'h10, 3'd0), 1'b0, 1'b0);
        check("lw_sh", bus.mrd_o, 32'h1234aa0d);

        step(mk_store(32'h13, 32'hffffffff, 3'd0), 1'b0, 1'b0);
        check("err_misalign", 32'(bus.addr_err_o), 32'd1);
        step(mk_store(32'h4000, 32'hffffffff, 3'd0), 1'b0, 1'b0);
        check("err_range", 32'(bus.addr_err_o), 32'd1);
        step(mk_load(32'h10, 3'd0), 1'b0, 1'b0);
        check("err_nowrite", bus.mrd_o, 32'h1234aa0d);
        step(mk_load(32'h0, 3'd0), 1'b0, 1'b0);
        check("err_nowrap", bus.mrd_o, 32'h0);

        s = nop; s.tnew = 2'd2; step(s, 1'b0, 1'b0);
        check("tnew2", 32'(bus.Tnew_o), 32'd1);
        s.tnew = 2'd1; step(s, 1'b0, 1'b0);
        check("tnew1", 32'(bus.Tnew_o), 32'd0);
        s.tnew = 2'd0; step(s, 1'b0, 1'b0);
        check("tnew0", 32'(bus.Tnew_o), 32'd0);

        s = mk_store(32'h20, 32'hdeadbeef, 3'd0); s.regwe = 1'b1;
        step(s, 1'b0, 1'b1);
        check("flush_regwe", 32'(bus.RegWE_o), 32'd0);
        step(mk_load(32'h20, 3'd0), 1'b0, 1'b0);
        check("flush_nowrite", bus.mrd_o, 32'h0);

        s = nop; s.wd_sel = 2'b10; s.regwe = 1'b1; s.pcadd4 = 32'h3008; s.ao = 32'h55;
        step(s, 1'b0, 1'b0);
        check("fwd_pc8", bus.fwd_data_o, 32'h3008);

        for (int n = 0; n < 500; n++) begin
            int unsigned k = $urandom_range(0, 3);
            logic [2:0] t = 3'($urandom_range(0, 4));
            if (k == 0) begin
                s = mk_load(rand_addr(), t);
            end else if (k == 1) begin
                s = mk_store(rand_addr(), $urandom, t);
            end else begin
                s = '0;
                s.ao = rand_addr(); s.mtype = t; s.regwe = 1'($urandom_range(0, 1));
                s.wd_sel = 2'($urandom_range(1, 2)); s.pcadd4 = $urandom;
            end
            s.pc = $urandom; s.a3 = 5'($urandom); s.tnew = 2'($urandom_range(0, 3));
            if (k != 1) s.wdata = $urandom;
            step(s, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
